// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - pipeline hazard, forwarding, flush and memory-wait freeze control
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int FWD_EN     = 1,
    parameter int MEM_WAIT   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src1,
    input  logic                  id_use_src2,
    input  logic [REG_ADDR_W-1:0] exe_src1,
    input  logic [REG_ADDR_W-1:0] exe_src2,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  wb_wb_en,
    input  logic                  mem_access,
    input  logic                  branch_taken,
    output logic                  hazard,
    output logic                  freeze,
    output logic                  flush,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      wait_cnt
);

    localparam int WCNT_W    = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
    localparam int WAIT_INIT = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic              mem_freeze;
    logic              raw_hazard;
    logic              s1_exe, s2_exe, s1_mem, s2_mem;

    function automatic logic [1:0] fwd_pick(input logic [REG_ADDR_W-1:0] src);
        if (mem_wb_en && (mem_dest == src))
            return 2'b01;
        else if (wb_wb_en && (wb_dest == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // DONE is the single unfrozen cycle in which the access completes; a new access is not accepted there
    always_comb begin
        mem_freeze = 1'b0;
        case (state)
            S_IDLE:  mem_freeze = mem_access && (MEM_WAIT > 0);
            S_WAIT:  mem_freeze = 1'b1;
            default: mem_freeze = 1'b0;
        endcase
    end

    always_comb begin
        s1_exe     = id_use_src1 && exe_wb_en && (id_src1 == exe_dest);
        s2_exe     = id_use_src2 && exe_wb_en && (id_src2 == exe_dest);
        s1_mem     = id_use_src1 && mem_wb_en && (id_src1 == mem_dest);
        s2_mem     = id_use_src2 && mem_wb_en && (id_src2 == mem_dest);
        raw_hazard = 1'b0;
        if (FWD_EN != 0)
            raw_hazard = exe_mem_read && (s1_exe || s2_exe);
        else
            raw_hazard = s1_exe || s2_exe || s1_mem || s2_mem;
    end

    // Freeze outranks branch flush, which outranks the RAW stall
    always_comb begin
        hazard    = 1'b0;
        freeze    = 1'b0;
        flush     = 1'b0;
        fwd_sel_a = 2'b00;
        fwd_sel_b = 2'b00;
        if (!rst) begin
            freeze = mem_freeze;
            if (!mem_freeze) begin
                if (branch_taken)
                    flush = 1'b1;
                else
                    hazard = raw_hazard;
            end
            if (FWD_EN != 0) begin
                fwd_sel_a = fwd_pick(exe_src1);
                fwd_sel_b = fwd_pick(exe_src2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_access && (MEM_WAIT > 0)) begin
                        if (MEM_WAIT == 1) begin
                            state <= S_DONE;
                            wcnt  <= '0;
                        end else begin
                            state <= S_WAIT;
                            wcnt  <= WCNT_W'(WAIT_INIT);
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt <= WCNT_W'(1)) begin
                        state <= S_DONE;
                        wcnt  <= '0;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    state <= S_IDLE;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (hazard && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
            if (freeze && (wait_cnt != '1))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - self-checking bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] id_src1, id_src2, exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
    logic          id_use_src1, id_use_src2, exe_wb_en, exe_mem_read, mem_wb_en, wb_wb_en;
    logic          mem_access, branch_taken;

    logic        haz0, frz0, fl0, haz1, frz1, fl1;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [3:0]  sc0, fc0, wc0;
    logic [15:0] sc1, fc1, wc1;

    hazard_forward_ctrl #(.REG_ADDR_W(AW), .FWD_EN(1), .MEM_WAIT(2), .CNT_W(4)) u_fwd (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .mem_access(mem_access), .branch_taken(branch_taken),
        .hazard(haz0), .freeze(frz0), .flush(fl0), .fwd_sel_a(fa0), .fwd_sel_b(fb0),
        .stall_cnt(sc0), .flush_cnt(fc0), .wait_cnt(wc0));

    hazard_forward_ctrl #(.REG_ADDR_W(AW), .FWD_EN(0), .MEM_WAIT(0), .CNT_W(16)) u_nofwd (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .mem_access(mem_access), .branch_taken(branch_taken),
        .hazard(haz1), .freeze(frz1), .flush(fl1), .fwd_sel_a(fa1), .fwd_sel_b(fb1),
        .stall_cnt(sc1), .flush_cnt(fc1), .wait_cnt(wc1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: index 0 = forwarding, 2 wait states, 4-bit counters; index 1 = no forwarding, no waits
    int m_left[2], m_cool[2], m_stall[2], m_flush[2], m_wait[2];

    function automatic int fwd_of(input int i);  return (i == 0) ? 1 : 0;     endfunction
    function automatic int mw_of(input int i);   return (i == 0) ? 2 : 0;     endfunction
    function automatic int cmax_of(input int i); return (i == 0) ? 15 : 65535; endfunction

    function automatic int exp_sel(input int i, input logic [AW-1:0] src);
        if (rst || fwd_of(i) == 0) return 0;
        if (mem_wb_en && mem_dest == src) return 1;
        if (wb_wb_en && wb_dest == src) return 2;
        return 0;
    endfunction

    function automatic bit reads(input logic [AW-1:0] tag);
        return (id_use_src1 && id_src1 == tag) || (id_use_src2 && id_src2 == tag);
    endfunction

    function automatic bit raw(input int i);
        if (fwd_of(i) != 0) return exe_wb_en && exe_mem_read && reads(exe_dest);
        return (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
    endfunction

    function automatic bit exp_frz(input int i);
        if (rst) return 0;
        if (m_left[i] > 0) return 1;
        if (m_cool[i] != 0) return 0;
        return mem_access && mw_of(i) > 0;
    endfunction

    function automatic bit exp_fl(input int i);
        return !rst && !exp_frz(i) && branch_taken;
    endfunction

    function automatic bit exp_haz(input int i);
        return !rst && !exp_frz(i) && !branch_taken && raw(i);
    endfunction

    task automatic advance();
        for (int i = 0; i < 2; i++) begin
            bit fr, fl, hz;
            fr = exp_frz(i); fl = exp_fl(i); hz = exp_haz(i);
            if (rst) begin
                m_left[i] = 0; m_cool[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_wait[i] = 0;
            end else begin
                if (hz && m_stall[i] < cmax_of(i)) m_stall[i]++;
                if (fl && m_flush[i] < cmax_of(i)) m_flush[i]++;
                if (fr && m_wait[i] < cmax_of(i)) m_wait[i]++;
                if (m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_cool[i] = 1;
                end else if (m_cool[i] != 0) begin
                    m_cool[i] = 0;
                end else if (mem_access && mw_of(i) > 0) begin
                    m_left[i] = mw_of(i) - 1;
                    if (m_left[i] == 0) m_cool[i] = 1;
                end
            end
        end
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge
    task automatic step();
        #1;
        chk("haz0", haz0, exp_haz(0));  chk("haz1", haz1, exp_haz(1));
        chk("frz0", frz0, exp_frz(0));  chk("frz1", frz1, exp_frz(1));
        chk("fl0", fl0, exp_fl(0));     chk("fl1", fl1, exp_fl(1));
        chk("fa0", fa0, exp_sel(0, exe_src1)); chk("fb0", fb0, exp_sel(0, exe_src2));
        chk("fa1", fa1, exp_sel(1, exe_src1)); chk("fb1", fb1, exp_sel(1, exe_src2));
        chk("sc0", sc0, m_stall[0]); chk("fc0", fc0, m_flush[0]); chk("wc0", wc0, m_wait[0]);
        chk("sc1", sc1, m_stall[1]); chk("fc1", fc1, m_flush[1]); chk("wc1", wc1, m_wait[1]);
        advance();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_use_src2 = 0;
        exe_src1 = 0; exe_src2 = 0; exe_dest = 0; exe_wb_en = 0; exe_mem_read = 0;
        mem_dest = 0; mem_wb_en = 0; wb_dest = 0; wb_wb_en = 0; mem_access = 0; branch_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic load_use();
        exe_dest = 1; exe_wb_en = 1; exe_mem_read = 1;
        id_src1 = 1; id_use_src1 = 1; id_src2 = 2; id_use_src2 = 1;
    endtask

    typedef struct {
        logic [AW-1:0] s1, s2;
        logic          u1, u2;
        logic [AW-1:0] es1, es2, ed;
        logic          ewb, eld;
        logic [AW-1:0] md;
        logic          mwb;
        logic [AW-1:0] wd;
        logic          wwb, br;
        logic          eh0, ef0;
        logic [1:0]    ea0, eb0;
        logic          eh1;
    } vec_t;

    vec_t tbl[10];
    int   frz_seq[6];

    initial begin
        tbl[0] = '{1, 2, 1, 1, 7, 8, 1, 1, 1, 5, 0, 6, 0, 0, 1, 0, 0, 0, 1};
        tbl[1] = '{1, 2, 1, 1, 7, 8, 1, 1, 0, 5, 0, 6, 0, 0, 0, 0, 0, 0, 1};
        tbl[2] = '{3, 4, 1, 0, 1, 2, 9, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 3, 3, 1, 1, 3, 1, 3, 1, 0, 0, 0, 0, 1, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 3, 3, 1, 1, 3, 0, 3, 1, 0, 0, 0, 0, 2, 0};
        tbl[5] = '{1, 2, 1, 1, 7, 8, 1, 1, 1, 5, 0, 6, 0, 1, 0, 1, 0, 0, 0};
        tbl[6] = '{1, 1, 0, 1, 7, 8, 1, 1, 1, 5, 0, 6, 0, 0, 1, 0, 0, 0, 1};
        tbl[7] = '{5, 9, 1, 0, 5, 8, 2, 1, 1, 5, 1, 6, 0, 0, 0, 0, 1, 0, 1};
        tbl[8] = '{1, 1, 0, 0, 7, 8, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[9] = '{1, 2, 1, 1, 7, 8, 1, 0, 1, 1, 0, 6, 0, 0, 0, 0, 0, 0, 0};

        idle_inputs();
        rst = 1;
        @(negedge clk);
        step();
        rst = 0;
        chk("reset_sc0", sc0, 0); chk("reset_wc1", wc1, 0);

        // Table of combinational hazard / forwarding / flush cases
        for (int k = 0; k < 10; k++) begin
            id_src1 = tbl[k].s1; id_src2 = tbl[k].s2; id_use_src1 = tbl[k].u1; id_use_src2 = tbl[k].u2;
            exe_src1 = tbl[k].es1; exe_src2 = tbl[k].es2; exe_dest = tbl[k].ed;
            exe_wb_en = tbl[k].ewb; exe_mem_read = tbl[k].eld;
            mem_dest = tbl[k].md; mem_wb_en = tbl[k].mwb; wb_dest = tbl[k].wd; wb_wb_en = tbl[k].wwb;
            branch_taken = tbl[k].br; mem_access = 0;
            #1;
            chk($sformatf("tbl%0d_haz0", k), haz0, tbl[k].eh0);
            chk($sformatf("tbl%0d_fl0", k), fl0, tbl[k].ef0);
            chk($sformatf("tbl%0d_fa0", k), fa0, tbl[k].ea0);
            chk($sformatf("tbl%0d_fb0", k), fb0, tbl[k].eb0);
            chk($sformatf("tbl%0d_haz1", k), haz1, tbl[k].eh1);
            chk($sformatf("tbl%0d_fb1", k), fb1, 0);
            step();
        end

        // Single access held high: 1,1,0 then idle
        do_reset();
        frz_seq = '{1, 1, 0, 0, 0, 0};
        mem_access = 1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_access = 0;
            #1; chk($sformatf("single_frz%0d", k), frz0, frz_seq[k]); chk("single_frz1", frz1, 0);
            step();
        end

        // Back-to-back accesses: 1,1,0,1,1,0 and four wait cycles counted
        do_reset();
        frz_seq = '{1, 1, 0, 1, 1, 0};
        mem_access = 1;
        for (int k = 0; k < 6; k++) begin
            #1; chk($sformatf("b2b_frz%0d", k), frz0, frz_seq[k]);
            step();
        end
        mem_access = 0;
        chk("b2b_wait_cnt", wc0, 4);

        // Branch with a load-use hazard pending, while frozen: flush held off until freeze drops
        do_reset();
        load_use();
        branch_taken = 1; mem_access = 1;
        frz_seq = '{0, 0, 1, 0, 0, 0};
        for (int k = 0; k < 3; k++) begin
            #1; chk($sformatf("brfrz_fl%0d", k), fl0, frz_seq[k]); chk("brfrz_haz", haz0, 0);
            chk("brfrz_fl1", fl1, 1);
            step();
        end
        mem_access = 0; branch_taken = 0;

        // Reset during WAIT aborts the access
        do_reset();
        mem_access = 1;
        step();
        mem_access = 0; rst = 1;
        #1; chk("rstwait_frz_in_rst", frz0, 0);
        step();
        rst = 0;
        #1; chk("rstwait_frz_after", frz0, 0); chk("rstwait_wc0", wc0, 0); chk("rstwait_sc0", sc0, 0);
        step();

        // Stall counter saturation with 4-bit counters
        do_reset();
        load_use();
        for (int k = 0; k < 20; k++) step();
        chk("sat_sc0", sc0, 15); chk("sat_sc1", sc1, 20);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) < 3);
            id_src1 = AW'($urandom_range(0, 3)); id_src2 = AW'($urandom_range(0, 3));
            id_use_src1 = 1'($urandom); id_use_src2 = 1'($urandom);
            exe_src1 = AW'($urandom_range(0, 3)); exe_src2 = AW'($urandom_range(0, 3));
            exe_dest = AW'($urandom_range(0, 3)); exe_wb_en = 1'($urandom); exe_mem_read = 1'($urandom);
            mem_dest = AW'($urandom_range(0, 3)); mem_wb_en = 1'($urandom);
            wb_dest = AW'($urandom_range(0, 3)); wb_wb_en = 1'($urandom);
            mem_access = ($urandom_range(0, 99) < 30);
            branch_taken = ($urandom_range(0, 99) < 15);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
